// File: rtl/load_store_unit.sv
// Load/store front end for a word-organised data memory with byte write mask.
// It turns one processor request at a time into an aligned word access, then
// returns the sign- or zero-extended load data or an error flag.
// Misaligned, illegal-size and out-of-range requests never touch memory.
module load_store_unit #(
   parameter int MEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_addr,
   output logic        mem_rstrb,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_WAIT,
      S_RESP
   } state_t;

   localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic [1:0]  lo_q, lo_d;
   logic        uns_q, uns_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_wmask_q, mem_wmask_d;
   logic        mem_rstrb_q, mem_rstrb_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;

   logic        req_err;
   logic [3:0]  store_mask;
   logic [31:0] store_data;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_data;

   // Decode the incoming request: legality, byte mask and lane-replicated data.
   always_comb begin
      req_err    = 1'b0;
      store_mask = 4'b0000;
      store_data = req_wdata;
      case (req_size)
         2'd0: begin
            store_mask = 4'b0001 << req_addr[1:0];
            store_data = {4{req_wdata[7:0]}};
         end
         2'd1: begin
            store_mask = req_addr[1] ? 4'b1100 : 4'b0011;
            store_data = {2{req_wdata[15:0]}};
            req_err    = req_addr[0];
         end
         2'd2: begin
            store_mask = 4'b1111;
            req_err    = (req_addr[1:0] != 2'b00);
         end
         default: req_err = 1'b1;
      endcase
      if ({2'b00, req_addr[31:2]} >= MEM_WORDS_U) begin
         req_err = 1'b1;
      end
   end

   // Pick the addressed lane out of the returned word and extend it.
   always_comb begin
      byte_lane = mem_rdata[{lo_q, 3'b000} +: 8];
      half_lane = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (size_q)
         2'd0:    load_data = {{24{byte_lane[7] & ~uns_q}}, byte_lane};
         2'd1:    load_data = {{16{half_lane[15] & ~uns_q}}, half_lane};
         default: load_data = mem_rdata;
      endcase
   end

   // Next-state and output logic; strobes and the response pulse default low.
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      size_d      = size_q;
      lo_d        = lo_q;
      uns_d       = uns_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wmask_d = 4'b0000;
      mem_rstrb_d = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d   = req_we;
               size_d = req_size;
               lo_d   = req_addr[1:0];
               uns_d  = req_unsigned;
               if (req_err) begin
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = 32'h0;
               end else begin
                  state_d    = S_ACCESS;
                  mem_addr_d = {req_addr[31:2], 2'b00};
                  if (req_we) begin
                     mem_wdata_d = store_data;
                     mem_wmask_d = store_mask;
                  end else begin
                     mem_rstrb_d = 1'b1;
                  end
               end
            end
         end
         S_ACCESS: begin
            if (we_q) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = 32'h0;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = load_data;
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         size_q      <= 2'd0;
         lo_q        <= 2'd0;
         uns_q       <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         mem_wmask_q <= 4'b0000;
         mem_rstrb_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         size_q      <= size_d;
         lo_q        <= lo_d;
         uns_q       <= uns_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wmask_q <= mem_wmask_d;
         mem_rstrb_q <= mem_rstrb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wmask = mem_wmask_q;
   assign mem_rstrb = mem_rstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a byte-addressed reference memory predicts each
// response and its timing; a per-cycle compare process checks the DUT.
module tb_load_store_unit;

   localparam int MEM_WORDS = 1024;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_addr;
   logic        mem_rstrb;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .mem_addr     (mem_addr),
      .mem_rstrb    (mem_rstrb),
      .mem_wdata    (mem_wdata),
      .mem_wmask    (mem_wmask),
      .mem_rdata    (mem_rdata)
   );

   // Attached memory: byte-masked write, registered read on strobe.
   logic [31:0] phys [0:MEM_WORDS-1];
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (mem_wmask[i]) phys[mem_addr[11:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
      if (mem_rstrb) mem_rdata <= phys[mem_addr[11:2]];
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model state
   logic [7:0]  ref_bytes [0:4*MEM_WORDS-1];
   int          edge_n = 0;
   bit          chk_en = 1'b0;
   bit          cur_valid = 1'b0;
   int          cur_T, cur_lat;
   bit          cur_we, cur_err;
   logic [31:0] cur_addr, cur_rdata, cur_wdata;
   logic [3:0]  cur_mask;
   int          acc_count = 0, rsp_count = 0, last_acc_T = 0, acc_gap = 0;
   logic [31:0] last_addr, last_wdata, last_rdata;
   logic [3:0]  last_wmask;
   logic        last_err;
   int          last_rsp_cyc;

   always @(posedge clk) edge_n <= edge_n + 1;

   function automatic logic [31:0] lane_bits(input logic [3:0] m);
      logic [31:0] r;
      r = 32'h0;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
      return r;
   endfunction

   // Predict the outcome of a request accepted at the coming edge.
   task automatic model_accept();
      int n;
      int a;
      logic [31:0] v;
      if (cur_valid) check("req_ready_busy", {31'b0, req_ready}, 32'h0);
      acc_count++;
      acc_gap    = edge_n + 1 - last_acc_T;
      last_acc_T = edge_n + 1;
      cur_valid  = 1'b1;
      cur_T      = edge_n + 1;
      cur_we     = req_we;
      cur_addr   = req_addr;
      cur_mask   = 4'b0;
      cur_wdata  = 32'h0;
      cur_rdata  = 32'h0;
      n = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
      cur_err = (req_size == 2'd3) || (req_addr % n != 0) || (req_addr / 4 >= MEM_WORDS);
      a = int'(req_addr & 32'hFFF);
      if (cur_err) begin
         cur_lat = 0;
      end else if (req_we) begin
         cur_lat = 1;
         for (int i = 0; i < n; i++) begin
            ref_bytes[a+i] = req_wdata[8*i +: 8];
            cur_mask[(a+i) % 4] = 1'b1;
            cur_wdata[8*((a+i) % 4) +: 8] = req_wdata[8*i +: 8];
         end
      end else begin
         cur_lat = 2;
         v = 32'h0;
         for (int i = n - 1; i >= 0; i--) v = (v << 8) | 32'(ref_bytes[a+i]);
         if (n < 4 && !req_unsigned && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
         cur_rdata = v;
      end
   endtask

   // Just before each rising edge: reset abandons, otherwise note accepts.
   always @(negedge clk) begin
      #4;
      if (resetn !== 1'b1) cur_valid = 1'b0;
      else if (req_valid && req_ready) model_accept();
   end

   task automatic compare_cycle();
      bit strobe, rspc;
      strobe = cur_valid && !cur_err && (edge_n == cur_T);
      rspc   = cur_valid && (edge_n == cur_T + cur_lat);
      check("req_ready", {31'b0, req_ready}, {31'b0, !cur_valid});
      check("mem_rstrb", {31'b0, mem_rstrb}, {31'b0, strobe && !cur_we});
      check("mem_wmask", {28'b0, mem_wmask}, {28'b0, (strobe && cur_we) ? cur_mask : 4'b0});
      if (strobe) begin
         check("mem_addr", mem_addr, cur_addr & ~32'h3);
         if (cur_we) check("mem_wdata_lanes", mem_wdata & lane_bits(cur_mask), cur_wdata);
         last_addr  = mem_addr;
         last_wdata = mem_wdata;
         last_wmask = mem_wmask;
      end
      check("rsp_valid", {31'b0, rsp_valid}, {31'b0, rspc});
      if (rspc && rsp_valid) begin
         check("rsp_rdata", rsp_rdata, cur_rdata);
         check("rsp_err", {31'b0, rsp_err}, {31'b0, cur_err});
         rsp_count++;
         last_rdata   = rsp_rdata;
         last_err     = rsp_err;
         last_rsp_cyc = edge_n - cur_T + 1;
      end
      if (cur_valid && edge_n >= cur_T + cur_lat) cur_valid = 1'b0;
   endtask

   always @(negedge clk) if (chk_en) compare_cycle();

   // Present a request at a falling edge and wait for its acceptance.
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata, input bit keep);
      int start;
      bit got;
      req_we       = we;
      req_addr     = addr;
      req_size     = size;
      req_unsigned = uns;
      req_wdata    = wdata;
      req_valid    = 1'b1;
      start = acc_count;
      got   = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (acc_count != start) got = 1'b1;
      end
      check("accept_count", acc_count - start, 1);
      if (!keep) begin
         req_valid    = 1'b0;
         req_we       = ~we;
         req_addr     = 32'hFFFF_FFFC;
         req_size     = 2'd3;
         req_wdata    = 32'h5A5A_5A5A;
         req_unsigned = ~uns;
      end
   endtask

   task automatic wait_done();
      for (int i = 0; i < 20 && cur_valid; i++) @(negedge clk);
      check("rsp_timeout", {31'b0, cur_valid}, 32'h0);
      @(negedge clk);
   endtask

   task automatic txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata);
      do_req(we, addr, size, uns, wdata, 1'b0);
      wait_done();
      $display("txn we=%0d addr=0x%08h size=%0d uns=%0d wdata=0x%08h -> rdata=0x%08h err=%0d cyc=T+%0d",
               we, addr, size, uns, wdata, last_rdata, last_err, last_rsp_cyc);
   endtask

   task automatic err_case(input string name, input logic we, input logic [31:0] addr, input logic [1:0] size);
      txn(we, addr, size, 1'b0, 32'h1234_5678);
      check({name, "_err"}, {31'b0, last_err}, 32'h1);
      check({name, "_rdata"}, last_rdata, 32'h0);
      check({name, "_cyc"}, last_rsp_cyc, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'h0);
      check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
      check({tag, "_rsp_err"}, {31'b0, rsp_err}, 32'h0);
      check({tag, "_mem_addr"}, mem_addr, 32'h0);
      check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
      check({tag, "_mem_rstrb"}, {31'b0, mem_rstrb}, 32'h0);
      check({tag, "_mem_wmask"}, {28'b0, mem_wmask}, 32'h0);
      check({tag, "_req_ready"}, {31'b0, req_ready}, 32'h1);
   endtask

   initial begin
      int acc0, rsp0;
      resetn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
      req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 32'h0;
      for (int i = 0; i < 4*MEM_WORDS; i++) ref_bytes[i] = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      chk_en = 1'b1;
      resetn = 1'b1;
      @(negedge clk);

      // Word store then load
      txn(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEAD_BEEF);
      check("wstore_mask", {28'b0, last_wmask}, 32'hF);
      check("wstore_cyc", last_rsp_cyc, 2);
      txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
      check("wload_rdata", last_rdata, 32'hDEAD_BEEF);
      check("wload_err", {31'b0, last_err}, 32'h0);
      check("wload_cyc", last_rsp_cyc, 3);

      // Byte lanes
      txn(1'b1, 32'h23, 2'd0, 1'b0, 32'h1234_5680);
      check("bstore_addr", last_addr, 32'h20);
      check("bstore_wdata", last_wdata, 32'h8080_8080);
      check("bstore_mask", {28'b0, last_wmask}, 32'h8);
      txn(1'b0, 32'h23, 2'd0, 1'b0, 32'h0);
      check("bload_signed", last_rdata, 32'hFFFF_FF80);
      txn(1'b0, 32'h23, 2'd0, 1'b1, 32'h0);
      check("bload_unsigned", last_rdata, 32'h0000_0080);

      // Halfwords
      txn(1'b1, 32'h40, 2'd2, 1'b0, 32'h8001_7FFF);
      txn(1'b0, 32'h42, 2'd1, 1'b0, 32'h0);
      check("hload_hi_signed", last_rdata, 32'hFFFF_8001);
      txn(1'b0, 32'h40, 2'd1, 1'b0, 32'h0);
      check("hload_lo_signed", last_rdata, 32'h0000_7FFF);
      txn(1'b1, 32'h42, 2'd1, 1'b0, 32'h7777_ABCD);
      check("hstore_mask", {28'b0, last_wmask}, 32'hC);
      check("hstore_wdata", last_wdata, 32'hABCD_ABCD);
      txn(1'b0, 32'h40, 2'd2, 1'b0, 32'h0);
      check("hstore_readback", last_rdata, 32'hABCD_7FFF);

      // Errors
      err_case("err_word_misalign", 1'b0, 32'h02, 2'd2);
      err_case("err_half_misalign", 1'b1, 32'h05, 2'd1);
      err_case("err_size3", 1'b0, 32'h00, 2'd3);
      err_case("err_range", 1'b0, 32'h1000, 2'd2);

      // Back-to-back loads with req_valid held high
      acc0 = acc_count; rsp0 = rsp_count;
      do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 1'b1);
      do_req(1'b0, 32'h23, 2'd0, 1'b1, 32'h0, 1'b1);
      check("load_gap", acc_gap, 4);
      do_req(1'b0, 32'h42, 2'd1, 1'b1, 32'h0, 1'b0);
      check("load_gap", acc_gap, 4);
      wait_done();
      check("hs_unsigned_half", last_rdata, 32'h0000_ABCD);
      check("hs_accepts", acc_count - acc0, 3);
      check("hs_responses", rsp_count - rsp0, 3);
      $display("handshake: 3 loads accepted=%0d responses=%0d", acc_count - acc0, rsp_count - rsp0);

      // Back-to-back stores
      do_req(1'b1, 32'h80, 2'd2, 1'b0, 32'h0102_0304, 1'b1);
      do_req(1'b1, 32'h84, 2'd2, 1'b0, 32'hA0B0_C0D0, 1'b0);
      check("store_gap", acc_gap, 3);
      wait_done();
      txn(1'b0, 32'h84, 2'd2, 1'b0, 32'h0);
      check("store_b2b_readback", last_rdata, 32'hA0B0_C0D0);

      // Reset during WAIT of a load
      do_req(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      check_reset_outputs("midreset");
      $display("reset mid-load: outputs checked after release");
      repeat (4) @(negedge clk);
      txn(1'b0, 32'h40, 2'd2, 1'b0, 32'h0);
      check("post_reset_load", last_rdata, 32'hABCD_7FFF);
      check("rsp_per_accept", rsp_count, acc_count - 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
